// File: rtl/mem_access_stage_v2_if.sv
// Bundles the EX->MEM inputs, the MEM/WB outputs, the hazard-unit stall request
// and the debug read port of the MEM stage.
//   master : pipeline side (drives the EX-side signals, observes MEM/WB outputs)
//   slave  : the MEM stage itself
interface mem_access_stage_v2_if #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_ADDR = 10
) ();
    logic               i_halt;
    logic [4:0]         i_reg2write;
    logic [NB_DATA-1:0] i_result;
    logic [NB_DATA-1:0] i_data4Mem;
    logic [1:0]         i_width;
    logic               i_sign_flag;
    logic               i_memRead;
    logic               i_memWrite;
    logic               i_mem2reg;
    logic               i_regWrite;
    logic [NB_ADDR-1:0] i_dbg_addr;
    logic [NB_DATA-1:0] o_dbg_data;
    logic [NB_DATA-1:0] o_reg_read;
    logic [NB_DATA-1:0] o_ALUresult;
    logic [4:0]         o_reg2write;
    logic               o_mem2reg;
    logic               o_regWrite;
    logic               o_misaligned;
    logic               o_stall_req;

    modport master (
        output i_halt, i_reg2write, i_result, i_data4Mem, i_width, i_sign_flag,
               i_memRead, i_memWrite, i_mem2reg, i_regWrite, i_dbg_addr,
        input  o_dbg_data, o_reg_read, o_ALUresult, o_reg2write, o_mem2reg,
               o_regWrite, o_misaligned, o_stall_req
    );

    modport slave (
        input  i_halt, i_reg2write, i_result, i_data4Mem, i_width, i_sign_flag,
               i_memRead, i_memWrite, i_mem2reg, i_regWrite, i_dbg_addr,
        output o_dbg_data, o_reg_read, o_ALUresult, o_reg2write, o_mem2reg,
               o_regWrite, o_misaligned, o_stall_req
    );
endinterface

// File: rtl/mem_access_stage_v2.sv
// MEM pipeline stage: byte-addressed little-endian data RAM with per-byte write
// enables, sub-word load extraction/extension, configurable access latency with
// a stall request FSM, misalignment flagging and a combinational debug read port.
// Ports:
//   clk   : clock
//   i_rst : synchronous active-high reset (FSM, counter, MEM/WB register; not RAM)
//   bus   : EX-side inputs, MEM/WB outputs, o_stall_req (comb), debug port (comb)
module mem_access_stage_v2 #(
    parameter int unsigned NB_DATA     = 32,
    parameter int unsigned NB_ADDR     = 10,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  i_rst,
    mem_access_stage_v2_if.slave  bus
);
    localparam int unsigned DEPTH  = 2 ** (NB_ADDR - 2);
    localparam int unsigned NB_CNT = 4;
    localparam logic [NB_CNT-1:0] CNT_INIT =
        NB_CNT'((MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, next_state;
    logic [NB_CNT-1:0]  cnt, next_cnt;
    logic               stall_c, complete_c;

    logic [NB_DATA-1:0] ram [DEPTH];
    logic [NB_ADDR-1:0] addr;
    logic [NB_ADDR-3:0] waddr;
    logic [NB_DATA-1:0] rd_word;
    logic               access_c, mis_c, we_c;
    logic [3:0]         be_c;
    logic [NB_DATA-1:0] wdata_c, load_c;
    logic [7:0]         byte_c;
    logic [15:0]        half_c;

    logic [NB_DATA-1:0] reg_read_q, alu_q;
    logic [4:0]         r2w_q;
    logic               m2r_q, rw_q, mis_q;
    logic [1:0]         unused_dbg_lsb;

    assign addr     = bus.i_result[NB_ADDR-1:0];
    assign waddr    = addr[NB_ADDR-1:2];
    assign rd_word  = ram[waddr];
    assign access_c = bus.i_memRead | bus.i_memWrite;

    // Only memory accesses can fault; width 11 is always illegal.
    assign mis_c = access_c & ((bus.i_width == 2'b01 && addr[0]) ||
                               (bus.i_width == 2'b10 && addr[1:0] != 2'b00) ||
                               (bus.i_width == 2'b11));

    // Store lanes: data replicated, byte enables pick the target lane(s).
    always_comb begin
        be_c    = 4'b0000;
        wdata_c = bus.i_data4Mem;
        case (bus.i_width)
            2'b00: begin
                be_c    = 4'b0001 << addr[1:0];
                wdata_c = {4{bus.i_data4Mem[7:0]}};
            end
            2'b01: begin
                be_c    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{bus.i_data4Mem[15:0]}};
            end
            2'b10:   be_c = 4'b1111;
            default: be_c = 4'b0000;
        endcase
    end

    // Load extraction and extension from the asynchronously read word.
    always_comb begin
        byte_c = rd_word[{addr[1:0], 3'b000} +: 8];
        half_c = rd_word[{addr[1], 4'b0000} +: 16];
        load_c = rd_word;
        case (bus.i_width)
            2'b00:   load_c = {{24{bus.i_sign_flag & byte_c[7]}}, byte_c};
            2'b01:   load_c = {{16{bus.i_sign_flag & half_c[15]}}, half_c};
            default: load_c = rd_word;
        endcase
    end

    // Access FSM: next state, counter and stall request.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        stall_c    = 1'b0;
        complete_c = 1'b0;
        case (state)
            IDLE: begin
                if (access_c && !mis_c && !bus.i_halt && (MEM_LATENCY > 1)) begin
                    stall_c    = 1'b1;
                    next_cnt   = CNT_INIT;
                    next_state = BUSY;
                end else begin
                    complete_c = 1'b1;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    stall_c  = 1'b1;
                    next_cnt = cnt - NB_CNT'(1);
                end else begin
                    complete_c = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register; halt freezes it.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (!bus.i_halt) begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // RAM write on the final cycle of an aligned store; reset aborts it.
    assign we_c = complete_c & bus.i_memWrite & ~mis_c & ~bus.i_halt & ~i_rst;

    always_ff @(posedge clk) begin
        if (we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) ram[waddr][8*b +: 8] <= wdata_c[8*b +: 8];
            end
        end
    end

    // MEM/WB register: full load on completion, bubble on stall cycles.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            reg_read_q <= '0;
            alu_q      <= '0;
            r2w_q      <= '0;
            m2r_q      <= 1'b0;
            rw_q       <= 1'b0;
            mis_q      <= 1'b0;
        end else if (!bus.i_halt) begin
            if (complete_c) begin
                reg_read_q <= (bus.i_memRead && !mis_c) ? load_c : '0;
                alu_q      <= bus.i_result;
                r2w_q      <= bus.i_reg2write;
                m2r_q      <= bus.i_mem2reg;
                rw_q       <= bus.i_regWrite & ~mis_c;
                mis_q      <= mis_c;
            end else begin
                rw_q  <= 1'b0;
                mis_q <= 1'b0;
            end
        end
    end

    // Debug port is word-granular; the two byte-offset bits are ignored.
    assign unused_dbg_lsb   = bus.i_dbg_addr[1:0];
    assign bus.o_dbg_data   = ram[bus.i_dbg_addr[NB_ADDR-1:2]];
    assign bus.o_stall_req  = stall_c;
    assign bus.o_reg_read   = reg_read_q;
    assign bus.o_ALUresult  = alu_q;
    assign bus.o_reg2write  = r2w_q;
    assign bus.o_mem2reg    = m2r_q;
    assign bus.o_regWrite   = rw_q;
    assign bus.o_misaligned = mis_q;
endmodule

// File: tb/tb_mem_access_stage_v2.sv
// Scoreboard bench: two stage instances (latency 1 and latency 3) share the
// stimulus; only the selected one is out of reset. A byte-array memory model
// predicts each completion, a monitor pops and compares on every completing edge.
module tb_mem_access_stage_v2;
    logic        clk;
    logic        rst1, rst3, sel;
    logic        halt, rd, wr, sgn, m2r, rw;
    logic [1:0]  w;
    logic [31:0] res, dat;
    logic [4:0]  r2w;
    logic [9:0]  dbg;

    mem_access_stage_v2_if #(.NB_DATA(32), .NB_ADDR(10)) if1 ();
    mem_access_stage_v2_if #(.NB_DATA(32), .NB_ADDR(10)) if3 ();

    assign if1.i_halt = halt;      assign if3.i_halt = halt;
    assign if1.i_reg2write = r2w;  assign if3.i_reg2write = r2w;
    assign if1.i_result = res;     assign if3.i_result = res;
    assign if1.i_data4Mem = dat;   assign if3.i_data4Mem = dat;
    assign if1.i_width = w;        assign if3.i_width = w;
    assign if1.i_sign_flag = sgn;  assign if3.i_sign_flag = sgn;
    assign if1.i_memRead = rd;     assign if3.i_memRead = rd;
    assign if1.i_memWrite = wr;    assign if3.i_memWrite = wr;
    assign if1.i_mem2reg = m2r;    assign if3.i_mem2reg = m2r;
    assign if1.i_regWrite = rw;    assign if3.i_regWrite = rw;
    assign if1.i_dbg_addr = dbg;   assign if3.i_dbg_addr = dbg;

    mem_access_stage_v2 #(.NB_DATA(32), .NB_ADDR(10), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .i_rst(rst1), .bus(if1.slave));
    mem_access_stage_v2 #(.NB_DATA(32), .NB_ADDR(10), .MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .i_rst(rst3), .bus(if3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] reg_read;
        logic [31:0] alu;
        logic [4:0]  r2w;
        logic        m2r;
        logic        rw;
        logic        mis;
    } wb_t;

    wb_t         cur, prev, e;
    logic        m_stall;
    logic [31:0] m_dbg;
    wb_t         expq[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mdl [2][1024];

    always_comb begin
        cur.reg_read = sel ? if3.o_reg_read   : if1.o_reg_read;
        cur.alu      = sel ? if3.o_ALUresult  : if1.o_ALUresult;
        cur.r2w      = sel ? if3.o_reg2write  : if1.o_reg2write;
        cur.m2r      = sel ? if3.o_mem2reg    : if1.o_mem2reg;
        cur.rw       = sel ? if3.o_regWrite   : if1.o_regWrite;
        cur.mis      = sel ? if3.o_misaligned : if1.o_misaligned;
        m_stall      = sel ? if3.o_stall_req  : if1.o_stall_req;
        m_dbg        = sel ? if3.o_dbg_data   : if1.o_dbg_data;
    end

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int s, input int a);
        int b;
        b = a - (a % 4);
        return {mdl[s][b+3], mdl[s][b+2], mdl[s][b+1], mdl[s][b]};
    endfunction

    // Issue one instruction at a negedge, hold it for its whole latency
    // (optionally halting at cycle h_at for h_len cycles) and check the stall
    // request every cycle plus the debug word in its first cycle.
    task automatic issue(input logic i_rd, input logic i_wr, input logic [1:0] i_w,
                         input logic i_sgn, input logic [31:0] i_res, input logic [31:0] i_dat,
                         input logic [4:0] i_r2w, input logic i_m2r, input logic i_rw,
                         input int h_at, input int h_len, input logic [9:0] i_dbg);
        int s, a, v, n;
        logic acc, mis;
        logic [31:0] lv, dbg_exp;
        wb_t x;
        s   = int'(sel);
        a   = int'(i_res[9:0]);
        acc = i_rd | i_wr;
        mis = acc && (i_w == 2'b11 || (i_w == 2'b01 && a % 2 != 0) ||
                      (i_w == 2'b10 && a % 4 != 0));
        n   = (acc && !mis && sel) ? 3 : 1;
        dbg_exp = model_word(s, int'(i_dbg));
        lv = 32'h0;
        if (i_w == 2'b00) begin
            v = int'(mdl[s][a]);
            if (i_sgn && v >= 128) v -= 256;
            lv = 32'(v);
        end else if (i_w == 2'b01) begin
            v = int'(mdl[s][a]) + 256 * int'(mdl[s][a+1]);
            if (i_sgn && v >= 32768) v -= 65536;
            lv = 32'(v);
        end else if (i_w == 2'b10) begin
            lv = model_word(s, a);
        end
        x.reg_read = (i_rd && !mis) ? lv : 32'h0;
        x.alu      = i_res;
        x.r2w      = i_r2w;
        x.m2r      = i_m2r;
        x.rw       = i_rw && !mis;
        x.mis      = mis;
        expq.push_back(x);
        if (i_wr && !mis)
            for (int i = 0; i < (1 << i_w); i++) mdl[s][a+i] = i_dat[8*i +: 8];
        rd = i_rd; wr = i_wr; w = i_w; sgn = i_sgn; res = i_res; dat = i_dat;
        r2w = i_r2w; m2r = i_m2r; rw = i_rw; dbg = i_dbg;
        for (int k = 0; k < n; k++) begin
            if (k == h_at) begin
                for (int h = 0; h < h_len; h++) begin
                    halt = 1'b1;
                    #1 chk("stall_halted", 72'(m_stall), 72'(k < n - 1));
                    @(negedge clk);
                end
                halt = 1'b0;
            end
            #1 chk("stall", 72'(m_stall), 72'(k < n - 1));
            if (k == 0) chk("dbg_data", 72'(m_dbg), 72'(dbg_exp));
            @(negedge clk);
        end
    endtask

    task automatic st(input logic [1:0] sw, input int a, input logic [31:0] d);
        issue(1'b0, 1'b1, sw, 1'b0, 32'(a), d, 5'd0, 1'b0, 1'b0, -1, 0, 10'(a));
    endtask

    task automatic ld(input logic [1:0] lw, input logic s, input int a);
        issue(1'b1, 1'b0, lw, s, 32'(a), 32'h0, 5'(a), 1'b1, 1'b1, -1, 0, 10'(a));
    endtask

    task automatic init_window();
        for (int i = 0; i < 16; i++) st(2'b10, 4 * i, $urandom());
    endtask

    task automatic rand_instr();
        int kind, a, hat, hlen;
        logic [1:0] rw_w;
        logic [31:0] hi;
        kind = $urandom_range(0, 2);
        rw_w = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        a    = $urandom_range(0, 63);
        if ($urandom_range(0, 1) == 1 && rw_w != 2'b11) a = a - (a % (1 << rw_w));
        hi   = $urandom();
        hat  = -1;
        hlen = 0;
        if ($urandom_range(0, 4) == 0) begin
            hat  = sel ? $urandom_range(1, 2) : 0;
            hlen = $urandom_range(1, 3);
        end
        issue(kind == 1, kind == 2, rw_w, 1'($urandom_range(0, 1)), {hi[31:10], 10'(a)},
              $urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), hat, hlen, 10'($urandom_range(0, 63)));
    endtask

    // Monitor: classify each edge from pre-edge conditions, then check outputs.
    initial begin
        logic p_rst, p_halt, p_stall;
        forever begin
            @(negedge clk);
            #2;
            p_rst   = sel ? rst3 : rst1;
            p_halt  = halt;
            p_stall = m_stall;
            prev    = cur;
            @(posedge clk);
            #1;
            if (p_rst) begin
                chk("reset_outputs", 72'(cur), 72'h0);
            end else if (p_halt) begin
                chk("halt_frozen", 72'(cur), 72'(prev));
            end else if (p_stall) begin
                e = prev;
                e.rw  = 1'b0;
                e.mis = 1'b0;
                chk("bubble", 72'(cur), 72'(e));
            end else if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion @%0t: got 0x%0h, expected none", $time, cur);
            end else begin
                e = expq.pop_front();
                chk("wb_output", 72'(cur), 72'(e));
            end
        end
    end

    initial begin
        sel = 1'b0; rst1 = 1'b1; rst3 = 1'b1; halt = 1'b0;
        rd = 1'b0; wr = 1'b0; w = 2'b00; sgn = 1'b0; res = '0; dat = '0;
        r2w = '0; m2r = 1'b0; rw = 1'b0; dbg = '0;
        repeat (3) @(negedge clk);

        // Latency 1
        rst1 = 1'b0;
        init_window();
        st(2'b10, 32'h10, 32'hDEADBEEF);
        ld(2'b10, 1'b0, 32'h10);
        ld(2'b10, 1'b0, 32'h10);
        st(2'b10, 32'h04, 32'h0);
        st(2'b00, 32'h05, 32'h00000080);
        ld(2'b10, 1'b0, 32'h04);
        ld(2'b00, 1'b1, 32'h05);
        ld(2'b00, 1'b0, 32'h05);
        st(2'b10, 32'h04, 32'hAABBCCDD);
        st(2'b01, 32'h06, 32'h00001234);
        ld(2'b10, 1'b0, 32'h04);
        ld(2'b01, 1'b1, 32'h03);
        ld(2'b10, 1'b0, 32'h04);
        for (int i = 0; i < 150; i++) rand_instr();

        // Switch to latency 3
        rst1 = 1'b1;
        rd = 1'b0; wr = 1'b0;
        repeat (2) @(negedge clk);
        sel  = 1'b1;
        rst3 = 1'b0;
        init_window();
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd7, 1'b1, 1'b1, -1, 0, 10'h10);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 5'd9, 1'b1, 1'b1, 1, 4, 10'h14);
        ld(2'b01, 1'b0, 32'h03);

        // Reset pulsed while a store is in BUSY: store must not land.
        rd = 1'b0; wr = 1'b1; w = 2'b10; res = 32'h20; dat = 32'h5A5A5A5A; dbg = 10'h20;
        rw = 1'b0;
        #1 chk("rst_abort_stall0", 72'(m_stall), 72'h1);
        @(negedge clk);
        rst3 = 1'b1;
        #1 chk("rst_abort_stall1", 72'(m_stall), 72'h1);
        @(negedge clk);
        rst3 = 1'b0;
        issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, -1, 0, 10'h20);
        ld(2'b10, 1'b0, 32'h20);

        for (int i = 0; i < 150; i++) rand_instr();

        chk("queue_drained", 72'(expq.size()), 72'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
